// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel counters plus registered dv/hsync/vsync/line/frame strobes.
// One-cycle registered latency from en; en low freezes all state; rst is async active-low.
module vga_timing_gen #(
   parameter int HRES   = 1600,
   parameter int H_FP   = 24,
   parameter int H_SYNC = 80,
   parameter int H_BP   = 96,
   parameter int VRES   = 900,
   parameter int V_FP   = 1,
   parameter int V_SYNC = 3,
   parameter int V_BP   = 96,
   parameter bit HS_POL = 1'b1,
   parameter bit VS_POL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [10:0] h_cnt,
   output logic [10:0] v_cnt,
   output logic        vga_dv_o,
   output logic        vga_hs_o,
   output logic        vga_vs_o,
   output logic        line_start,
   output logic        frame_start
);

   localparam int HTOTAL   = HRES + H_FP + H_SYNC + H_BP;
   localparam int VTOTAL   = VRES + V_FP + V_SYNC + V_BP;
   localparam int HS_START = HRES + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = VRES + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(VTOTAL - 1);

   if (HTOTAL > 2048 || VTOTAL > 2048) begin : g_bad_totals
      $error("vga_timing_gen: HTOTAL and VTOTAL must not exceed 2048");
   end

   logic [10:0] hn;
   logic [10:0] vn;
   logic [11:0] hx;
   logic [11:0] vx;
   logic        dv_n;
   logic        hs_n;
   logic        vs_n;

   always_comb begin
      hn = h_cnt + 11'd1;
      vn = v_cnt;
      if (h_cnt == H_LAST) begin
         hn = 11'd0;
         vn = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
      end
   end

   // Decode from the next-state counters so each strobe lines up with the count it describes.
   // 12-bit compares keep a 2048-wide window from aliasing to zero.
   assign hx   = {1'b0, hn};
   assign vx   = {1'b0, vn};
   assign dv_n = (hx < 12'(HRES)) && (vx < 12'(VRES));
   assign hs_n = (hx >= 12'(HS_START) && hx < 12'(HS_END)) ? HS_POL : ~HS_POL;
   assign vs_n = (vx >= 12'(VS_START) && vx < 12'(VS_END)) ? VS_POL : ~VS_POL;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_cnt       <= H_LAST;
         v_cnt       <= V_LAST;
         vga_dv_o    <= 1'b0;
         vga_hs_o    <= ~HS_POL;
         vga_vs_o    <= ~VS_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (en) begin
         h_cnt       <= hn;
         v_cnt       <= vn;
         vga_dv_o    <= dv_n;
         vga_hs_o    <= hs_n;
         vga_vs_o    <= vs_n;
         line_start  <= (hn == 11'd0);
         frame_start <= (hn == 11'd0) && (vn == 11'd0);
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: three generator instances (default timing, small raster, small raster
// with inverted sync polarity) against a linear-pixel-index reference model.
module tb_vga_timing_gen;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        dv;
      logic        hs;
      logic        vs;
      logic        ls;
      logic        fs;
   } obs_t;

   logic clk;
   logic rst;
   logic en;

   logic [10:0] h0, v0, h1, v1, h2, v2;
   logic dv0, hs0, vs0, ls0, fs0;
   logic dv1, hs1, vs1, ls1, fs1;
   logic dv2, hs2, vs2, ls2, fs2;

   obs_t q0[$];
   obs_t q1[$];
   obs_t q2[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pd     = -1;
   int ps     = -1;

   vga_timing_gen u_def (
      .clk(clk), .rst(rst), .en(en), .h_cnt(h0), .v_cnt(v0),
      .vga_dv_o(dv0), .vga_hs_o(hs0), .vga_vs_o(vs0),
      .line_start(ls0), .frame_start(fs0)
   );

   vga_timing_gen #(
      .HRES(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .VRES(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) u_small (
      .clk(clk), .rst(rst), .en(en), .h_cnt(h1), .v_cnt(v1),
      .vga_dv_o(dv1), .vga_hs_o(hs1), .vga_vs_o(vs1),
      .line_start(ls1), .frame_start(fs1)
   );

   vga_timing_gen #(
      .HRES(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .VRES(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) u_neg (
      .clk(clk), .rst(rst), .en(en), .h_cnt(h2), .v_cnt(v2),
      .vga_dv_o(dv2), .vga_hs_o(hs2), .vga_vs_o(vs2),
      .line_start(ls2), .frame_start(fs2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // pos is the linear pixel index since the last frame start; -1 means "in reset".
   function automatic obs_t model(input int pos, input int hres, input int hfp, input int hsw,
                                  input int hbp, input int vres, input int vfp, input int vsw,
                                  input int vbp, input bit hpol, input bit vpol);
      obs_t e;
      int ht, vt, h, v;
      ht = hres + hfp + hsw + hbp;
      vt = vres + vfp + vsw + vbp;
      if (pos < 0) begin
         e.h  = 11'(ht - 1);
         e.v  = 11'(vt - 1);
         e.dv = 1'b0;
         e.hs = ~hpol;
         e.vs = ~vpol;
         e.ls = 1'b0;
         e.fs = 1'b0;
      end else begin
         h    = pos % ht;
         v    = pos / ht;
         e.h  = 11'(h);
         e.v  = 11'(v);
         e.dv = (h < hres) && (v < vres);
         e.hs = (h >= hres + hfp && h < hres + hfp + hsw) ? hpol : ~hpol;
         e.vs = (v >= vres + vfp && v < vres + vfp + vsw) ? vpol : ~vpol;
         e.ls = (h == 0);
         e.fs = (pos == 0);
      end
      return e;
   endfunction

   task automatic check(input string name, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got h=%0d v=%0d dv=%b hs=%b vs=%b ls=%b fs=%b expected h=%0d v=%0d dv=%b hs=%b vs=%b ls=%b fs=%b",
                  name, cyc, got.h, got.v, got.dv, got.hs, got.vs, got.ls, got.fs,
                  exp.h, exp.v, exp.dv, exp.hs, exp.vs, exp.ls, exp.fs);
      end
   endtask

   // Monitor: compare sampled outputs on the falling edge against queued expectations.
   initial begin
      obs_t e;
      forever begin
         @(negedge clk);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check("default", {h0, v0, dv0, hs0, vs0, ls0, fs0}, e);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check("small_pos", {h1, v1, dv1, hs1, vs1, ls1, fs1}, e);
         end
         if (q2.size() > 0) begin
            e = q2.pop_front();
            check("small_neg", {h2, v2, dv2, hs2, vs2, ls2, fs2}, e);
         end
      end
   end

   // One clock: advance the model with the inputs seen at this edge, then apply new inputs.
   // A pulse drops rst after the edge and releases it after the falling-edge sample.
   task automatic step(input bit new_rst, input bit new_en, input bit pulse);
      @(posedge clk);
      cyc++;
      if (rst && en) begin
         pd = (pd + 1) % (1800 * 1000);
         ps = (ps + 1) % (12 * 7);
      end
      #1;
      rst = new_rst;
      en  = new_en;
      if (!rst) begin
         pd = -1;
         ps = -1;
      end
      q0.push_back(model(pd, 1600, 24, 80, 96, 900, 1, 3, 96, 1'b1, 1'b1));
      q1.push_back(model(ps, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1));
      q2.push_back(model(ps, 8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0));
      if (pulse) begin
         #6;
         rst = 1'b1;
      end
   endtask

   initial begin
      rst = 1'b0;
      en  = 1'b0;
      // Reset held with en high: reset values must persist.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
      // Release and run past one full default line plus many small frames.
      for (int i = 0; i < 2000; i++) step(1'b1, 1'b1, 1'b0);
      // Short freeze of three cycles.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
      // Mid-frame partial-cycle reset pulse, then resume.
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0);
      // Randomized enable with occasional asynchronous reset pulses.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
         else step(1'b1, ($urandom_range(0, 9) < 7), 1'b0);
      end
      for (int i = 0; i < 1900; i++) step(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      checks++;
      if (q0.size() + q1.size() + q2.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", q0.size() + q1.size() + q2.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that produces the pixel counters and the VGA control strobes `vga_dv_o`, `vga_hs_o` and `vga_vs_o`.
- Sits directly upstream of the video processing pipeline and the regression tester.
- The tester loads one input pixel per `h_cnt` change while `vga_dv_o` is high, and delays dv/hs/vs by one clock to align them with its output.
- Default timing: 1600x900 @ 60 Hz, reduced blanking, 108 MHz pixel clock, one pixel per enabled clock.

Parameters:
- HRES, 1600, active pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 80, horizontal sync width (pixels)
- H_BP, 96, horizontal back porch (pixels)
- VRES, 900, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BP, 96, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level (1 = active-high)

Ports:
- clk  input  1  pixel clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- en  input  1  pixel enable; when 0, all state and outputs hold
- h_cnt  output  11  horizontal position, 0..HTOTAL-1
- v_cnt  output  11  vertical position, 0..VTOTAL-1
- vga_dv_o  output  1  active-video strobe
- vga_hs_o  output  1  horizontal sync, polarity per HS_POL
- vga_vs_o  output  1  vertical sync, polarity per VS_POL
- line_start  output  1  one-enabled-cycle pulse when h_cnt==0
- frame_start  output  1  one-enabled-cycle pulse when h_cnt==0 and v_cnt==0

Behaviour:
- Derived totals: HTOTAL = HRES+H_FP+H_SYNC+H_BP (default 1800); VTOTAL = VRES+V_FP+V_SYNC+V_BP (default 1000).
  - Both totals must be ≤ 2048. This is a compile-time check: elaboration fails otherwise.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset (rst==0, asynchronous):
  - h_cnt = HTOTAL-1, v_cnt = VTOTAL-1.
  - vga_dv_o = 0, line_start = 0, frame_start = 0.
  - vga_hs_o = ~HS_POL, vga_vs_o = ~VS_POL (both inactive).
- Reset release: the first rising edge with en==1 wraps the counters to (0,0). In that same cycle vga_dv_o=1, line_start=1 and frame_start=1.
- Counters advance on each rising edge with en==1:
  - If h_cnt==HTOTAL-1: h_cnt←0, and v_cnt←(v_cnt==VTOTAL-1 ? 0 : v_cnt+1).
  - Otherwise: h_cnt←h_cnt+1; v_cnt holds.
- Strobes are decoded from the next-state counter values (hn, vn) and registered, so each strobe is aligned in the same cycle as the counter value it describes:
  - vga_dv_o = (hn < HRES) && (vn < VRES)
  - vga_hs_o = HS_POL when HRES+H_FP ≤ hn < HRES+H_FP+H_SYNC, else ~HS_POL
  - vga_vs_o = VS_POL when VRES+V_FP ≤ vn < VRES+V_FP+V_SYNC, else ~VS_POL
    - vsync is line-granular: it changes only when hn==0.
  - line_start = (hn==0); frame_start = (hn==0 && vn==0)
- en==0: the counters and every output register hold their current value.
  - line_start and frame_start also hold. Consumers must qualify these pulses with en.
- Reset asserted mid-frame: outputs go to their reset values immediately, without waiting for a clock edge. After release, the frame restarts at (0,0) as described above.
- Active lines: h_cnt changes every enabled clock, so the downstream `@(h_cnt)` sampling sees exactly HRES events with vga_dv_o=1 per active line.

Test Plan:
- Reset hold, then release with en=1 → reset values hold until the first edge. At that edge: h_cnt=0, v_cnt=0, vga_dv_o=1, frame_start=1, vga_hs_o=0, vga_vs_o=0.
- One full line at defaults → vga_dv_o high exactly for h_cnt 0..1599. vga_hs_o high exactly for h_cnt 1624..1703. At h_cnt=1799→0, v_cnt increments and line_start=1 for one cycle.
- Full frame with small params (HRES=8, H_FP=1, H_SYNC=2, H_BP=1, VRES=4, V_FP=1, V_SYNC=1, V_BP=1) → period 12×7=84 clocks between frame_start pulses. 32 cycles with dv=1. vga_vs_o high for v_cnt==5 only (12 clocks).
- Polarity check with HS_POL=0, VS_POL=0 → the sync windows read 0 and are 1 elsewhere, including at reset.
- en toggling (en=0 for 3 cycles at h_cnt=5, v_cnt=2) → all outputs frozen for 3 cycles, then the counters resume at h_cnt=6 with no skipped or duplicated count.
- rst pulsed low for a partial cycle at h_cnt=700, v_cnt=450 → outputs go to reset values without a clock edge. After release, the next enabled edge gives (0,0) with frame_start=1.
